// File: rtl/connector_pkg.sv
// Shared connector types: itype encoding, trace field widths
// and the block packer accumulator states.
package connector_pkg;

  localparam int XLEN        = 32;
  localparam int ITYPE_LEN   = 4;
  localparam int IRETIRE_LEN = 32;
  localparam int CAUSE_LEN   = 5;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_STD  = 4'd0,
    ITYPE_EXC  = 4'd1,
    ITYPE_INT  = 4'd2,
    ITYPE_ERET = 4'd3,
    ITYPE_NTB  = 4'd4,
    ITYPE_TB   = 4'd5,
    ITYPE_UIJ  = 4'd6,
    ITYPE_IJ   = 4'd7,
    ITYPE_UCJ  = 4'd8,
    ITYPE_ICJ  = 4'd9,
    ITYPE_URET = 4'd10,
    ITYPE_IRET = 4'd11
  } itype_e;

  typedef enum logic {
    BP_EMPTY = 1'b0,
    BP_OPEN  = 1'b1
  } block_packer_state_e;

endpackage

// File: rtl/block_packer_if.sv
// Output block bundle from the packer toward the encoder
// ingress FIFO, valid/ready handshake.
interface block_packer_if #(
  parameter int XLEN        = connector_pkg::XLEN,
  parameter int ITYPE_LEN   = connector_pkg::ITYPE_LEN,
  parameter int IRETIRE_LEN = connector_pkg::IRETIRE_LEN,
  parameter int CAUSE_LEN   = connector_pkg::CAUSE_LEN
) ();

  logic                   block_valid_o;
  logic                   block_ready_i;
  logic [XLEN-1:0]        iaddr_o;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;

  modport master (
    output block_valid_o, iaddr_o, iretire_o,
    output ilastsize_o, itype_o, cause_o, tval_o,
    input  block_ready_i
  );

  modport slave (
    input  block_valid_o, iaddr_o, iretire_o,
    input  ilastsize_o, itype_o, cause_o, tval_o,
    output block_ready_i
  );

endinterface

// File: rtl/block_packer.sv
// Packs committed instructions into E-trace ingress blocks and
// presents them through a one-entry registered output.
module block_packer #(
  parameter int XLEN        = connector_pkg::XLEN,
  parameter int ITYPE_LEN   = connector_pkg::ITYPE_LEN,
  parameter int IRETIRE_LEN = connector_pkg::IRETIRE_LEN,
  parameter int CAUSE_LEN   = connector_pkg::CAUSE_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 compressed_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [ITYPE_LEN-1:0] itype_i,
  input  logic [CAUSE_LEN-1:0] cause_i,
  input  logic [XLEN-1:0]      tval_i,
  block_packer_if.master       blk,
  output logic                 overflow_o
);

  import connector_pkg::*;

  block_packer_state_e state_q, state_d;

  logic [XLEN-1:0]        acc_addr_q, acc_addr_d;
  logic [IRETIRE_LEN-1:0] acc_cnt_q, acc_cnt_d;
  logic                   acc_last_q, acc_last_d;

  logic [31:0]            ity;
  logic                   is_trap, is_ret, is_plain, open;
  logic [IRETIRE_LEN-1:0] incr;
  logic [IRETIRE_LEN:0]   sum;

  logic                   close, load;
  logic [XLEN-1:0]        c_addr;
  logic [IRETIRE_LEN-1:0] c_cnt;
  logic                   c_last;
  logic [ITYPE_LEN-1:0]   c_itype;
  logic [CAUSE_LEN-1:0]   c_cause;
  logic [XLEN-1:0]        c_tval;

  assign ity      = 32'(itype_i);
  assign open     = (state_q == BP_OPEN);
  assign is_trap  = (ity == 32'd1) || (ity == 32'd2);
  assign is_ret   = valid_i && (ity >= 32'd3) && (ity <= 32'd11);
  assign is_plain = valid_i && (ity == 32'd0);
  assign incr     = compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign sum      = {1'b0, acc_cnt_q} + {1'b0, incr};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BP_EMPTY;
      acc_addr_q <= '0;
      acc_cnt_q  <= '0;
      acc_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_addr_q <= acc_addr_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_last_q <= acc_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_addr_d = acc_addr_q;
    acc_cnt_d  = acc_cnt_q;
    acc_last_d = acc_last_q;
    close      = 1'b0;
    c_addr     = acc_addr_q;
    c_cnt      = acc_cnt_q;
    c_last     = acc_last_q;
    c_itype    = '0;
    c_cause    = '0;
    c_tval     = '0;
    unique case (1'b1)
      is_trap: begin
        close   = 1'b1;
        c_itype = itype_i;
        c_cause = cause_i;
        c_tval  = tval_i;
        state_d = BP_EMPTY;
        if (!open) begin
          c_addr = pc_i;
          c_cnt  = '0;
          c_last = 1'b0;
        end
      end
      is_ret: begin
        close   = 1'b1;
        c_itype = itype_i;
        c_last  = ~compressed_i;
        state_d = BP_EMPTY;
        if (open) begin
          c_cnt = sum[IRETIRE_LEN-1:0];
        end else begin
          c_addr = pc_i;
          c_cnt  = incr;
        end
      end
      is_plain: begin
        state_d    = BP_OPEN;
        acc_last_d = ~compressed_i;
        if (!open) begin
          acc_addr_d = pc_i;
          acc_cnt_d  = incr;
        end else if (sum[IRETIRE_LEN]) begin
          // counter full: ship the held block, this commit starts fresh
          close      = 1'b1;
          acc_addr_d = pc_i;
          acc_cnt_d  = incr;
        end else begin
          acc_cnt_d = sum[IRETIRE_LEN-1:0];
        end
      end
      default: ;
    endcase
  end

  assign load = close && (!blk.block_valid_o || blk.block_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk.block_valid_o <= 1'b0;
      blk.iaddr_o       <= '0;
      blk.iretire_o     <= '0;
      blk.ilastsize_o   <= 1'b0;
      blk.itype_o       <= '0;
      blk.cause_o       <= '0;
      blk.tval_o        <= '0;
      overflow_o        <= 1'b0;
    end else begin
      if (load) begin
        blk.block_valid_o <= 1'b1;
        blk.iaddr_o       <= c_addr;
        blk.iretire_o     <= c_cnt;
        blk.ilastsize_o   <= c_last;
        blk.itype_o       <= c_itype;
        blk.cause_o       <= c_cause;
        blk.tval_o        <= c_tval;
      end else if (blk.block_ready_i) begin
        blk.block_valid_o <= 1'b0;
      end
      if (close && !load) overflow_o <= 1'b1;
    end
  end

endmodule
